// File: rtl/nand_op_sequencer.sv
// Multi-cycle sequencer that builds eight bitwise functions from one shared
// NAND unit, evaluating one microstep per clock.

module nand_unit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] y
);
   assign y = ~(x & z);
endmodule

// state  | meaning
// S_IDLE | waiting for start; operands captured on start
// S_RUN  | executing one NAND microstep per cycle for the captured opcode
module nand_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [2:0] SRC_A  = 3'd0;
   localparam logic [2:0] SRC_B  = 3'd1;
   localparam logic [2:0] SRC_T1 = 3'd2;
   localparam logic [2:0] SRC_T2 = 3'd3;
   localparam logic [2:0] SRC_R  = 3'd4;

   localparam logic [1:0] DST_T1 = 2'd0;
   localparam logic [1:0] DST_T2 = 2'd1;
   localparam logic [1:0] DST_R  = 2'd2;

   state_t           state, state_nxt;
   logic [2:0]       op_r, step;
   logic [WIDTH-1:0] a_r, b_r, t1_r, t2_r, r_r;
   logic [2:0]       sel_x, sel_z;
   logic [1:0]       dst;
   logic             last;
   logic [WIDTH-1:0] nand_x, nand_z, nand_y;

   nand_unit #(.WIDTH(WIDTH)) u_nand (
      .x (nand_x),
      .z (nand_z),
      .y (nand_y)
   );

   // Microprogram ROM: operand sources, destination and last-step flag per (op, step)
   always_comb begin
      sel_x = SRC_A;
      sel_z = SRC_B;
      dst   = DST_R;
      last  = 1'b0;
      case (op_r)
         3'd0: last = 1'b1;
         3'd1: begin
            if (step == 3'd0) dst = DST_T1;
            else begin sel_x = SRC_T1; sel_z = SRC_T1; last = 1'b1; end
         end
         3'd2, 3'd3: begin
            case (step)
               3'd0:    begin sel_z = SRC_A; dst = DST_T1; end
               3'd1:    begin sel_x = SRC_B; dst = DST_T2; end
               3'd2:    begin sel_x = SRC_T1; sel_z = SRC_T2; last = (op_r == 3'd2); end
               default: begin sel_x = SRC_R; sel_z = SRC_R; last = 1'b1; end
            endcase
         end
         3'd4, 3'd5: begin
            case (step)
               3'd0:    dst = DST_T1;
               3'd1:    begin sel_z = SRC_T1; dst = DST_T2; end
               3'd2:    begin sel_x = SRC_B; sel_z = SRC_T1; end
               3'd3:    begin sel_x = SRC_T2; sel_z = SRC_R; last = (op_r == 3'd4); end
               default: begin sel_x = SRC_R; sel_z = SRC_R; last = 1'b1; end
            endcase
         end
         3'd6: begin sel_z = SRC_A; last = 1'b1; end
         default: begin
            if (step == 3'd0) begin sel_z = SRC_A; dst = DST_T1; end
            else begin sel_x = SRC_T1; sel_z = SRC_T1; last = 1'b1; end
         end
      endcase
   end

   always_comb begin
      case (sel_x)
         SRC_A:   nand_x = a_r;
         SRC_B:   nand_x = b_r;
         SRC_T1:  nand_x = t1_r;
         SRC_T2:  nand_x = t2_r;
         default: nand_x = r_r;
      endcase
      case (sel_z)
         SRC_A:   nand_z = a_r;
         SRC_B:   nand_z = b_r;
         SRC_T1:  nand_z = t1_r;
         SRC_T2:  nand_z = t2_r;
         default: nand_z = r_r;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         default: if (last)  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r     <= '0;
         step     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         t1_r     <= '0;
         t2_r     <= '0;
         r_r      <= '0;
         result   <= '0;
         done     <= 1'b0;
         op_count <= '0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (start) begin
               op_r <= op;
               a_r  <= a_in;
               b_r  <= b_in;
               step <= '0;
            end
         end else begin
            case (dst)
               DST_T1:  t1_r <= nand_y;
               DST_T2:  t2_r <= nand_y;
               default: r_r  <= nand_y;
            endcase
            if (last) begin
               result   <= nand_y;
               done     <= 1'b1;
               op_count <= op_count + CNT_W'(1);
               step     <= '0;
            end else begin
               step <= step + 3'd1;
            end
         end
      end
   end
endmodule
